// File: rtl/alu_mul_if.sv
// Multiply sequencer handshake plus its borrowed-ALU port group.
interface alu_mul_if #(parameter int P_WIDTH = 16);
    logic               start;
    logic [P_WIDTH-1:0] a;
    logic [P_WIDTH-1:0] b;
    logic               busy;
    logic               done;
    logic [P_WIDTH-1:0] product;
    logic               carry;
    logic               alu_enable;
    logic [3:0]         alu_opcode;
    logic [P_WIDTH-1:0] alu_a;
    logic [P_WIDTH-1:0] alu_b;
    logic [P_WIDTH-1:0] alu_c;
    logic [4:0]         alu_status;

    // Requester side: issues multiplies and supplies the shared ALU's results.
    modport master (
        output start, a, b, alu_c, alu_status,
        input  busy, done, product, carry, alu_enable, alu_opcode, alu_a, alu_b
    );

    // Sequencer side.
    modport slave (
        input  start, a, b, alu_c, alu_status,
        output busy, done, product, carry, alu_enable, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared combinational ALU,
// issuing one ADDU/LSH/RSH per cycle. Product is the low P_WIDTH bits.
module alu_mul_sequencer #(
    parameter int P_WIDTH = 16
) (
    input  logic      clk,
    input  logic      reset,
    alu_mul_if.slave  bus
);
    localparam int CW = $clog2(P_WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(P_WIDTH - 1);

    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_LSH  = 4'd10;
    localparam logic [3:0] OP_RSH  = 4'd11;

    typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [P_WIDTH-1:0] mcand, mplier, prod;
    logic               carry;
    logic [CW-1:0]      cnt;

    // State register; reset wins over everything, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state: iterations end once the shifted multiplier is zero (ALU zero
    // flag on the RSH) or after the last bit position.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0)  state_nxt = S_DONE;
                    else if (bus.b[0]) state_nxt = S_ADD;
                    else               state_nxt = S_SHL;
                end
            end
            S_ADD:  state_nxt = S_SHL;
            S_SHL:  state_nxt = S_SHR;
            S_SHR: begin
                if (bus.alu_status[3] || cnt == LAST_ITER) state_nxt = S_DONE;
                else if (bus.alu_c[0])                      state_nxt = S_ADD;
                else                                        state_nxt = S_SHL;
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: latch operands on an accepted start, then take each
    // ALU result back into the register the current step is working on.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        prod   <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                    end
                end
                S_ADD: begin
                    prod  <= bus.alu_c;
                    carry <= carry | bus.alu_status[0];
                end
                S_SHL: mcand <= bus.alu_c;
                S_SHR: begin
                    mplier <= bus.alu_c;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: ALU bus is zeroed whenever the sequencer does not own the ALU.
    always_comb begin
        bus.alu_enable = 1'b0;
        bus.alu_opcode = 4'd0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        case (state)
            S_ADD: begin
                bus.alu_enable = 1'b1;
                bus.alu_opcode = OP_ADDU;
                bus.alu_a      = mcand;
                bus.alu_b      = prod;
            end
            S_SHL: begin
                bus.alu_enable = 1'b1;
                bus.alu_opcode = OP_LSH;
                bus.alu_a      = mcand;
                bus.alu_b      = P_WIDTH'(1);
            end
            S_SHR: begin
                bus.alu_enable = 1'b1;
                bus.alu_opcode = OP_RSH;
                bus.alu_a      = mplier;
                bus.alu_b      = P_WIDTH'(1);
            end
            default: ;
        endcase
        bus.busy    = (state != S_IDLE);
        bus.done    = (state == S_DONE);
        bus.product = prod;
        bus.carry   = carry;
    end
endmodule
